sram_arb: RTL and testbench
===========================

# sram_arb

Two-port arbiter that shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch path and the core data load/store path. Slave side of the fetch port follows the ifetch_if slave handshake. The data port adds write enable and write data. The master side drives the sram_if master signals. Each port has at most one outstanding access, and a round-robin scheduler resolves same-cycle conflicts.

## Interface
- AW, 32, byte-address width of both requester ports
- DW, 32, data width (SRAM word, instruction, load/store data)
- SAW, 10, SRAM word-address width; SRAM word index = addr[SAW+1:2]

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req_vld  in  1  fetch request valid
- if_req_rdy  out  1  fetch request accepted
- if_req_pc  in  AW  fetch byte address
- if_rsp_vld  out  1  fetch response valid
- if_rsp_rdy  in  1  fetch response consumed
- if_rsp_ir  out  DW  fetched instruction
- d_req_vld  in  1  data request valid
- d_req_rdy  out  1  data request accepted
- d_req_addr  in  AW  data byte address
- d_req_wen  in  1  1 = write, 0 = read
- d_req_wdata  in  DW  write data
- d_rsp_vld  out  1  data response valid (read data or write ack)
- d_rsp_rdy  in  1  data response consumed
- d_rsp_rdata  out  DW  read data; 0 for write ack
- sram_addr  out  SAW  SRAM word address
- sram_wen  out  1  SRAM write strobe
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data, valid the cycle after address

## Operation
- A port is eligible when req_vld && (!pend || rsp_fire). pend is that port's outstanding-response flag. rsp_fire = rsp_vld && rsp_rdy.
- Grant: one eligible port per cycle. If both ports are eligible, grant the port not granted most recently. The last-grant pointer updates on every grant. Reset value of the pointer = data, so the first conflict goes to fetch.
- req_rdy = grant for that port. It is combinational from req_vld, pend, rsp_rdy and the pointer.
- Granted fetch: sram_addr = if_req_pc[SAW+1:2], sram_wen = 0.
- Granted data: sram_addr = d_req_addr[SAW+1:2], sram_wen = d_req_wen, sram_wdata = d_req_wdata.
- No grant: sram_addr = 0, sram_wen = 0, sram_wdata = 0.
- Address bits [1:0] and above SAW+1 are ignored. There is no misalignment or range fault.
- Response slot per port holds pend, fresh and hold[DW-1:0]:
  - On grant: pend ← 1, fresh ← 1.
  - In the cycle after a grant, rsp data = sram_rdata (fresh), or 0 for a write. If rsp_fire does not occur, hold ← that value and fresh ← 0.
  - Otherwise rsp data = hold, and it stays stable until rsp_fire.
  - On rsp_fire with no new grant: pend ← 0.
- rsp_vld = pend.

## Timing
- Reset: all outputs 0. pend, fresh and hold cleared, pointer = data.
- Reset mid-access drops in-flight responses. It must not generate sram_wen.
- Read latency: request handshake in cycle T, rsp_vld in T+1, with data from sram_rdata in T+1.
- Write: SRAM write in T, ack (rsp_vld, rdata = 0) in T+1.
- Throughput: one access per cycle in total. A port alone with rsp_rdy held high completes back-to-back, one per cycle.
- Backpressure: rsp_vld and data are held unchanged until rsp_rdy. The port takes no new grant until rsp_fire occurs, which may be in the same cycle as the grant.
- A rejected request (vld high, rdy low) must be held stable by the requester. The arbiter keeps no state for ungranted requests.

## Structure
- Package sram_arb_pkg:
  - enum arb_port_e {ARB_IF, ARB_DATA}
  - struct rsp_slot_t {pend, fresh, hold}
  - function word_addr(addr) for the [SAW+1:2] slice
- Sub-module sram_arb_rsp_slot: pend/fresh/hold logic plus the rsp data mux. It is instantiated once per port. The top level holds the pointer, grant logic and SRAM muxing.

## Test plan
- Fetch alone: pc = 0x0, 0x4, 0x8 back-to-back with rsp_rdy = 1 → if_req_rdy high every cycle, sram_addr = 0, 1, 2, and if_rsp_ir = SRAM words 0, 1, 2 each one cycle later.
- Conflict: both ports valid continuously → grants alternate IF, DATA, IF, DATA starting with IF after reset. No lost or duplicated responses.
- Write then read: data write 0xDEADBEEF to addr 0x10, then read 0x10 → sram_wen pulse with sram_addr = 4, ack rdata = 0, then read returns 0xDEADBEEF.
- Backpressure: fetch read while if_rsp_rdy = 0 for 3 cycles, SRAM rdata changed by an intervening data access → if_rsp_ir holds the original word and if_req_rdy stays 0 until the response is consumed.
- Same-cycle consume and issue: pend = 1, rsp_rdy = 1, new req_vld → request granted in that cycle and rsp_vld stays high next cycle with new data.
- Reset asserted mid-read → all rsp_vld and sram_wen are 0 immediately, and the next transaction after release behaves as from cold reset.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ARB_AW  = 32;
  localparam int ARB_DW  = 32;
  localparam int ARB_SAW = 10;

  // Requester identity, also used as the last-grant pointer encoding.
  typedef enum logic {
    ARB_IF   = 1'b0,
    ARB_DATA = 1'b1
  } arb_port_e;

  // Per-port response slot: outstanding flag, "data comes straight from the
  // SRAM this cycle" flag, and the captured word used while backpressured.
  typedef struct packed {
    logic              pend;
    logic              fresh;
    logic [ARB_DW-1:0] hold;
  } rsp_slot_t;

  // SRAM word index from a byte address; low two bits and high bits ignored.
  function automatic logic [ARB_SAW-1:0] word_addr(input logic [ARB_AW-1:0] addr);
    return addr[ARB_SAW+1:2];
  endfunction

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// One outstanding-response slot: tracks pend/fresh/hold and muxes the
// response data between live SRAM read data, zero (write ack) and the
// captured word held under backpressure.
module sram_arb_rsp_slot
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_i,
  input  logic              wen_i,
  input  logic              rsp_rdy_i,
  input  logic [ARB_DW-1:0] sram_rdata_i,
  output logic              rsp_vld_o,
  output logic [ARB_DW-1:0] rsp_data_o
);

  rsp_slot_t slot_q, slot_d;
  logic      wr_q, wr_d;
  logic      rsp_fire;

  assign rsp_vld_o = slot_q.pend;
  assign rsp_fire  = slot_q.pend && rsp_rdy_i;

  // Response data: live SRAM word (or 0 for a write) in the cycle after the grant, else the held copy.
  always_comb begin
    rsp_data_o = slot_q.hold;
    if (slot_q.fresh) begin
      rsp_data_o = wr_q ? '0 : sram_rdata_i;
    end
  end

  // Next slot state: a grant (possibly coinciding with a consume) restarts the slot;
  // an unconsumed fresh response is captured so it survives later SRAM traffic.
  always_comb begin
    slot_d = slot_q;
    wr_d   = wr_q;
    if (grant_i) begin
      slot_d.pend  = 1'b1;
      slot_d.fresh = 1'b1;
      wr_d         = wen_i;
    end else if (rsp_fire) begin
      slot_d.pend  = 1'b0;
      slot_d.fresh = 1'b0;
    end else if (slot_q.fresh) begin
      slot_d.hold  = rsp_data_o;
      slot_d.fresh = 1'b0;
    end
  end

  // Slot state register; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      wr_q   <= wr_d;
    end
  end

endmodule

// File: rtl/sram_arb.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction-fetch port and the data load/store port. Each port has at
// most one outstanding access; the SRAM sees at most one access per cycle.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int AW  = ARB_AW,
  parameter int DW  = ARB_DW,
  parameter int SAW = ARB_SAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req_vld,
  output logic           if_req_rdy,
  input  logic [AW-1:0]  if_req_pc,
  output logic           if_rsp_vld,
  input  logic           if_rsp_rdy,
  output logic [DW-1:0]  if_rsp_ir,
  input  logic           d_req_vld,
  output logic           d_req_rdy,
  input  logic [AW-1:0]  d_req_addr,
  input  logic           d_req_wen,
  input  logic [DW-1:0]  d_req_wdata,
  output logic           d_rsp_vld,
  input  logic           d_rsp_rdy,
  output logic [DW-1:0]  d_rsp_rdata,
  output logic [SAW-1:0] sram_addr,
  output logic           sram_wen,
  output logic [DW-1:0]  sram_wdata,
  input  logic [DW-1:0]  sram_rdata
);

  arb_port_e ptr_q, ptr_d;
  logic      elig_if, elig_d;
  logic      grant_if, grant_d;

  // A port may issue when it has nothing outstanding or its response is consumed this cycle.
  // Grants are suppressed while reset is held so no SRAM write can slip through.
  always_comb begin
    elig_if  = !rst && if_req_vld && (!if_rsp_vld || if_rsp_rdy);
    elig_d   = !rst && d_req_vld  && (!d_rsp_vld  || d_rsp_rdy);
    grant_if = elig_if && (!elig_d  || (ptr_q == ARB_DATA));
    grant_d  = elig_d  && (!elig_if || (ptr_q == ARB_IF));
  end

  assign if_req_rdy = grant_if;
  assign d_req_rdy  = grant_d;

  // SRAM request mux: the granted port drives address/strobe/data, idle drives zeros.
  always_comb begin
    sram_addr  = '0;
    sram_wen   = 1'b0;
    sram_wdata = '0;
    if (grant_if) begin
      sram_addr = word_addr(if_req_pc);
    end else if (grant_d) begin
      sram_addr  = word_addr(d_req_addr);
      sram_wen   = d_req_wen;
      sram_wdata = d_req_wdata;
    end
  end

  // Last-grant pointer follows every grant so the other port wins the next conflict.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_if) begin
      ptr_d = ARB_IF;
    end else if (grant_d) begin
      ptr_d = ARB_DATA;
    end
  end

  // Pointer register; starts at data so the first conflict favours fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= ARB_DATA;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  sram_arb_rsp_slot u_if_slot (
    .clk         (clk),
    .rst         (rst),
    .grant_i     (grant_if),
    .wen_i       (1'b0),
    .rsp_rdy_i   (if_rsp_rdy),
    .sram_rdata_i(sram_rdata),
    .rsp_vld_o   (if_rsp_vld),
    .rsp_data_o  (if_rsp_ir)
  );

  sram_arb_rsp_slot u_d_slot (
    .clk         (clk),
    .rst         (rst),
    .grant_i     (grant_d),
    .wen_i       (d_req_wen),
    .rsp_rdy_i   (d_rsp_rdy),
    .sram_rdata_i(sram_rdata),
    .rsp_vld_o   (d_rsp_vld),
    .rsp_data_o  (d_rsp_rdata)
  );

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a behavioural 1-cycle-latency SRAM.
module tb_sram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_vld, if_req_rdy;
  logic [31:0] if_req_pc;
  logic        if_rsp_vld, if_rsp_rdy;
  logic [31:0] if_rsp_ir;
  logic        d_req_vld, d_req_rdy;
  logic [31:0] d_req_addr;
  logic        d_req_wen;
  logic [31:0] d_req_wdata;
  logic        d_rsp_vld, d_rsp_rdy;
  logic [31:0] d_rsp_rdata;
  logic [9:0]  sram_addr;
  logic        sram_wen;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arb dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_vld (if_req_vld),
    .if_req_rdy (if_req_rdy),
    .if_req_pc  (if_req_pc),
    .if_rsp_vld (if_rsp_vld),
    .if_rsp_rdy (if_rsp_rdy),
    .if_rsp_ir  (if_rsp_ir),
    .d_req_vld  (d_req_vld),
    .d_req_rdy  (d_req_rdy),
    .d_req_addr (d_req_addr),
    .d_req_wen  (d_req_wen),
    .d_req_wdata(d_req_wdata),
    .d_rsp_vld  (d_rsp_vld),
    .d_rsp_rdy  (d_rsp_rdy),
    .d_rsp_rdata(d_rsp_rdata),
    .sram_addr  (sram_addr),
    .sram_wen   (sram_wen),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM: write on strobe, registered read.
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, sampling well away from the edge.
  task automatic settle();
    #3;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    rst = 1'b1;
    if_req_vld = 0; if_req_pc = 0; if_rsp_rdy = 0;
    d_req_vld = 0; d_req_addr = 0; d_req_wen = 0; d_req_wdata = 0; d_rsp_rdy = 0;
    tick(); tick();
    settle();
    chk("rst_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("rst_d_rdy", {31'b0, d_req_rdy}, 0);
    chk("rst_if_vld", {31'b0, if_rsp_vld}, 0);
    chk("rst_d_vld", {31'b0, d_rsp_vld}, 0);
    chk("rst_wen", {31'b0, sram_wen}, 0);
    chk("rst_addr", {22'b0, sram_addr}, 0);
    tick();
    rst = 1'b0;
    $display("reset released");

    // Conflict: both ports valid every cycle, fetch wins first.
    if_req_vld = 1; if_req_pc = 32'h20; if_rsp_rdy = 1;
    d_req_vld = 1; d_req_addr = 32'h40; d_req_wen = 0; d_rsp_rdy = 1;
    settle();
    chk("cf1_if_rdy", {31'b0, if_req_rdy}, 1);
    chk("cf1_d_rdy", {31'b0, d_req_rdy}, 0);
    chk("cf1_addr", {22'b0, sram_addr}, 8);
    $display("conflict cycle 1: grant IF");
    tick(); settle();
    chk("cf2_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("cf2_d_rdy", {31'b0, d_req_rdy}, 1);
    chk("cf2_addr", {22'b0, sram_addr}, 16);
    chk("cf2_if_vld", {31'b0, if_rsp_vld}, 1);
    chk("cf2_if_ir", if_rsp_ir, 32'h1000_0008);
    $display("conflict cycle 2: grant DATA");
    tick(); settle();
    chk("cf3_if_rdy", {31'b0, if_req_rdy}, 1);
    chk("cf3_d_rdy", {31'b0, d_req_rdy}, 0);
    chk("cf3_if_vld", {31'b0, if_rsp_vld}, 0);
    chk("cf3_d_vld", {31'b0, d_rsp_vld}, 1);
    chk("cf3_d_rdata", d_rsp_rdata, 32'h1000_0010);
    $display("conflict cycle 3: grant IF");
    tick(); settle();
    chk("cf4_d_rdy", {31'b0, d_req_rdy}, 1);
    chk("cf4_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("cf4_if_ir", if_rsp_ir, 32'h1000_0008);
    $display("conflict cycle 4: grant DATA");
    tick();
    if_req_vld = 0; d_req_vld = 0;
    settle();
    chk("cf5_d_vld", {31'b0, d_rsp_vld}, 1);
    chk("cf5_d_rdata", d_rsp_rdata, 32'h1000_0010);
    chk("cf5_if_vld", {31'b0, if_rsp_vld}, 0);
    tick(); settle();
    chk("cf6_d_vld", {31'b0, d_rsp_vld}, 0);

    // Fetch alone, back-to-back.
    tick();
    if_req_vld = 1; if_req_pc = 32'h0; if_rsp_rdy = 1;
    settle();
    chk("fa0_rdy", {31'b0, if_req_rdy}, 1);
    chk("fa0_addr", {22'b0, sram_addr}, 0);
    $display("fetch pc=0x0");
    tick();
    if_req_pc = 32'h4;
    settle();
    chk("fa1_rdy", {31'b0, if_req_rdy}, 1);
    chk("fa1_addr", {22'b0, sram_addr}, 1);
    chk("fa1_ir", if_rsp_ir, 32'h1000_0000);
    $display("fetch pc=0x4");
    tick();
    if_req_pc = 32'h8;
    settle();
    chk("fa2_rdy", {31'b0, if_req_rdy}, 1);
    chk("fa2_addr", {22'b0, sram_addr}, 2);
    chk("fa2_ir", if_rsp_ir, 32'h1000_0001);
    $display("fetch pc=0x8");
    tick();
    if_req_vld = 0;
    settle();
    chk("fa3_vld", {31'b0, if_rsp_vld}, 1);
    chk("fa3_ir", if_rsp_ir, 32'h1000_0002);
    tick(); settle();
    chk("fa4_vld", {31'b0, if_rsp_vld}, 0);

    // Write 0xDEADBEEF to 0x10 then read it back.
    tick();
    d_req_vld = 1; d_req_wen = 1; d_req_addr = 32'h10; d_req_wdata = 32'hDEAD_BEEF; d_rsp_rdy = 1;
    settle();
    chk("wr_rdy", {31'b0, d_req_rdy}, 1);
    chk("wr_wen", {31'b0, sram_wen}, 1);
    chk("wr_addr", {22'b0, sram_addr}, 4);
    chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
    $display("data write addr=0x10");
    tick();
    d_req_wen = 0; d_req_wdata = 0;
    settle();
    chk("ack_vld", {31'b0, d_rsp_vld}, 1);
    chk("ack_rdata", d_rsp_rdata, 0);
    chk("rd_wen", {31'b0, sram_wen}, 0);
    chk("rd_rdy", {31'b0, d_req_rdy}, 1);
    $display("data read addr=0x10");
    tick();
    d_req_vld = 0;
    settle();
    chk("rd_vld", {31'b0, d_rsp_vld}, 1);
    chk("rd_rdata", d_rsp_rdata, 32'hDEAD_BEEF);

    // Backpressure on fetch with an intervening data read.
    tick();
    if_req_vld = 1; if_req_pc = 32'hC; if_rsp_rdy = 0;
    settle();
    chk("bp0_rdy", {31'b0, if_req_rdy}, 1);
    $display("fetch pc=0xC with rsp_rdy low");
    tick();
    if_req_pc = 32'h14;
    d_req_vld = 1; d_req_wen = 0; d_req_addr = 32'h40;
    settle();
    chk("bp1_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("bp1_d_rdy", {31'b0, d_req_rdy}, 1);
    chk("bp1_ir", if_rsp_ir, 32'h1000_0003);
    tick();
    d_req_vld = 0;
    settle();
    chk("bp2_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("bp2_ir", if_rsp_ir, 32'h1000_0003);
    chk("bp2_d_rdata", d_rsp_rdata, 32'h1000_0010);
    tick(); settle();
    chk("bp3_if_rdy", {31'b0, if_req_rdy}, 0);
    chk("bp3_vld", {31'b0, if_rsp_vld}, 1);
    chk("bp3_ir", if_rsp_ir, 32'h1000_0003);
    tick();
    if_rsp_rdy = 1;
    settle();
    chk("ci_rdy", {31'b0, if_req_rdy}, 1);
    chk("ci_addr", {22'b0, sram_addr}, 5);
    chk("ci_ir", if_rsp_ir, 32'h1000_0003);
    $display("fetch pc=0x14 consume-and-issue");
    tick();
    if_req_vld = 0;
    settle();
    chk("ci_vld", {31'b0, if_rsp_vld}, 1);
    chk("ci_ir2", if_rsp_ir, 32'h1000_0005);
    tick(); settle();
    chk("ci_idle", {31'b0, if_rsp_vld}, 0);

    // Reset in the middle of an outstanding read with a write pending.
    tick();
    if_req_vld = 1; if_req_pc = 32'h18; if_rsp_rdy = 0;
    settle();
    chk("rm_grant", {31'b0, if_req_rdy}, 1);
    tick();
    if_req_vld = 0;
    d_req_vld = 1; d_req_wen = 1; d_req_addr = 32'h30; d_req_wdata = 32'h5555_5555;
    rst = 1;
    #1;
    chk("rm_if_vld", {31'b0, if_rsp_vld}, 0);
    chk("rm_d_vld", {31'b0, d_rsp_vld}, 0);
    chk("rm_wen", {31'b0, sram_wen}, 0);
    chk("rm_d_rdy", {31'b0, d_req_rdy}, 0);
    $display("reset asserted mid-read");
    tick(); tick();
    chk("rm_mem", mem[12], 32'h1000_000C);
    rst = 0;
    if_req_vld = 1; if_req_pc = 32'h1C; if_rsp_rdy = 1;
    d_req_wen = 0; d_req_addr = 32'h30; d_rsp_rdy = 1;
    settle();
    chk("pr_if_rdy", {31'b0, if_req_rdy}, 1);
    chk("pr_d_rdy", {31'b0, d_req_rdy}, 0);
    chk("pr_addr", {22'b0, sram_addr}, 7);
    $display("post-reset conflict: grant IF");
    tick();
    if_req_vld = 0;
    settle();
    chk("pr_d_rdy2", {31'b0, d_req_rdy}, 1);
    chk("pr_ir", if_rsp_ir, 32'h1000_0007);
    tick();
    d_req_vld = 0;
    settle();
    chk("pr_d_rdata", d_rsp_rdata, 32'h1000_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
